// File: rtl/keypad_scancode_decoder_if.sv
// ============================================================================
// Module   : keypad_scancode_decoder_if
// Brief    : Byte-stream in / held-key flags out bundle for the keypad decoder.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface keypad_scancode_decoder_if;
  logic [7:0] din;
  logic       dinValid;
  logic       key2IsPressed;
  logic       key4IsPressed;
  logic       key6IsPressed;
  logic       key8IsPressed;
  logic       keyEnterIsPressed;
  logic       keyPressPulse;

  // master = byte source / flag consumer side, slave = the decoder
  modport master (
    output din,
    output dinValid,
    input  key2IsPressed,
    input  key4IsPressed,
    input  key6IsPressed,
    input  key8IsPressed,
    input  keyEnterIsPressed,
    input  keyPressPulse
  );

  modport slave (
    input  din,
    input  dinValid,
    output key2IsPressed,
    output key4IsPressed,
    output key6IsPressed,
    output key8IsPressed,
    output keyEnterIsPressed,
    output keyPressPulse
  );
endinterface

`default_nettype wire

// File: rtl/keypad_scancode_decoder.sv
// ============================================================================
// Module   : keypad_scancode_decoder
// Brief    : PS/2 set-2 scan codes -> held flags for KP 2/4/6/8/Enter + press pulse.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module keypad_scancode_decoder #(
  parameter int PREFIX_TIMEOUT = 2_500_000
) (
  input  wire logic                    clk,
  input  wire logic                    resetN,
  keypad_scancode_decoder_if.slave     bus
);

  localparam int CNT_W = $clog2(PREFIX_TIMEOUT) + 1;

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_EXT     = 2'd1;
  localparam logic [1:0] c_BRK     = 2'd2;
  localparam logic [1:0] c_EXT_BRK = 2'd3;

  localparam logic [CNT_W-1:0] c_EXPIRE = CNT_W'(PREFIX_TIMEOUT - 1);

  localparam logic [7:0] c_CODE_EXT   = 8'hE0;
  localparam logic [7:0] c_CODE_BRK   = 8'hF0;
  localparam logic [7:0] c_CODE_KP2   = 8'h72;
  localparam logic [7:0] c_CODE_KP4   = 8'h6B;
  localparam logic [7:0] c_CODE_KP6   = 8'h74;
  localparam logic [7:0] c_CODE_KP8   = 8'h75;
  localparam logic [7:0] c_CODE_ENTER = 8'h5A;

  // flag bit order: [0]=2, [1]=4, [2]=6, [3]=8, [4]=Enter
  logic [1:0]       r_state;
  logic [1:0]       w_nextState;
  logic [CNT_W-1:0] r_timeoutCnt;
  logic [4:0]       r_flags;
  logic             r_pulse;

  logic             w_expired;
  logic             w_isPrefix;
  logic             w_isBreakSeq;
  logic [4:0]       w_keyHit;
  logic [4:0]       w_setMask;
  logic [4:0]       w_clrMask;
  logic             w_pulseNext;

  assign w_expired    = (r_state != c_IDLE) && (r_timeoutCnt == c_EXPIRE);
  assign w_isPrefix   = (bus.din == c_CODE_EXT) || (bus.din == c_CODE_BRK);
  assign w_isBreakSeq = (r_state == c_BRK) || (r_state == c_EXT_BRK);

  // State register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; a byte arriving on the expiry cycle takes precedence
  always_comb begin
    w_nextState = r_state;
    if (bus.dinValid) begin
      if (bus.din == c_CODE_EXT) begin
        w_nextState = c_EXT;
      end else if (bus.din == c_CODE_BRK) begin
        if ((r_state == c_EXT) || (r_state == c_EXT_BRK)) begin
          w_nextState = c_EXT_BRK;
        end else begin
          w_nextState = c_BRK;
        end
      end else begin
        w_nextState = c_IDLE;
      end
    end else if (w_expired) begin
      w_nextState = c_IDLE;
    end
  end

  // Prefix timeout counter: saturating, parked at zero while idle
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_timeoutCnt <= '0;
    end else if (bus.dinValid || (r_state == c_IDLE)) begin
      r_timeoutCnt <= '0;
    end else if (r_timeoutCnt != c_EXPIRE) begin
      r_timeoutCnt <= r_timeoutCnt + 1'b1;
    end
  end

  // Output logic: which flag a completed data byte sets or clears
  always_comb begin
    w_keyHit = 5'b00000;
    case (bus.din)
      c_CODE_KP2:   w_keyHit = 5'b00001;
      c_CODE_KP4:   w_keyHit = 5'b00010;
      c_CODE_KP6:   w_keyHit = 5'b00100;
      c_CODE_KP8:   w_keyHit = 5'b01000;
      c_CODE_ENTER: w_keyHit = 5'b10000;
      default:      w_keyHit = 5'b00000;
    endcase

    w_setMask = 5'b00000;
    w_clrMask = 5'b00000;
    if (bus.dinValid && !w_isPrefix) begin
      if (w_isBreakSeq) begin
        w_clrMask = w_keyHit;
      end else begin
        w_setMask = w_keyHit;
      end
    end
    // typematic repeats find the flag already set and stay silent
    w_pulseNext = |(w_setMask & ~r_flags);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_flags <= 5'b00000;
      r_pulse <= 1'b0;
    end else begin
      r_flags <= (r_flags & ~w_clrMask) | w_setMask;
      r_pulse <= w_pulseNext;
    end
  end

  assign bus.key2IsPressed     = r_flags[0];
  assign bus.key4IsPressed     = r_flags[1];
  assign bus.key6IsPressed     = r_flags[2];
  assign bus.key8IsPressed     = r_flags[3];
  assign bus.keyEnterIsPressed = r_flags[4];
  assign bus.keyPressPulse     = r_pulse;

endmodule

`default_nettype wire

// File: tb/tb_keypad_scancode_decoder.sv
// ============================================================================
// Module   : tb_keypad_scancode_decoder
// Brief    : Directed scan-code sequences checked against a key-state model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_keypad_scancode_decoder;

  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic resetN;
  int   checks = 0;
  int   failures = 0;
  int   pulseCount = 0;
  logic checkEn = 1'b0;

  always #5 clk = ~clk;

  keypad_scancode_decoder_if bus ();

  keypad_scancode_decoder #(.PREFIX_TIMEOUT(TIMEOUT)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  // {enter, 8, 6, 4, 2}
  wire [4:0] dutFlags = {bus.keyEnterIsPressed, bus.key8IsPressed, bus.key6IsPressed,
                         bus.key4IsPressed, bus.key2IsPressed};

  // ---------------- key-state model ----------------
  logic [4:0] mFlags;
  logic       mPulse;
  logic       mExt;
  logic       mBrk;
  int         mGap;
  logic [2:0] mIdx;
  wire        mLive = (mGap < TIMEOUT);

  function automatic logic [2:0] mapKey(input logic [7:0] code);
    case (code)
      8'h72:   return 3'd0;
      8'h6B:   return 3'd1;
      8'h74:   return 3'd2;
      8'h75:   return 3'd3;
      8'h5A:   return 3'd4;
      default: return 3'd7;
    endcase
  endfunction

  always_comb mIdx = mapKey(bus.din);

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      mFlags <= '0; mPulse <= 1'b0; mExt <= 1'b0; mBrk <= 1'b0; mGap <= 0;
    end else if (bus.dinValid) begin
      mGap   <= 0;
      mPulse <= 1'b0;
      if (bus.din == 8'hE0) begin
        mExt <= 1'b1; mBrk <= 1'b0;
      end else if (bus.din == 8'hF0) begin
        mBrk <= 1'b1; mExt <= mExt && mLive;
      end else begin
        mExt <= 1'b0; mBrk <= 1'b0;
        if (mIdx != 3'd7) begin
          if (mBrk && mLive) begin
            mFlags[mIdx] <= 1'b0;
          end else begin
            mFlags[mIdx] <= 1'b1;
            mPulse       <= !mFlags[mIdx];
          end
        end
      end
    end else begin
      mPulse <= 1'b0;
      if (mGap < TIMEOUT) mGap <= mGap + 1;
    end
  end

  // ---------------- every-cycle comparison ----------------
  always @(negedge clk) begin
    if (bus.keyPressPulse) pulseCount++;
    if (checkEn) begin
      checks++;
      if ({bus.keyPressPulse, dutFlags} !== {mPulse, mFlags}) begin
        failures++;
        $display("FAIL model_cmp t=%0t {pulse,flags} got=%b exp=%b", $time,
                 {bus.keyPressPulse, dutFlags}, {mPulse, mFlags});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic sendByte(input logic [7:0] b);
    @(negedge clk);
    bus.din      = b;
    bus.dinValid = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.dinValid = 1'b0;
    end
  endtask

  task automatic expect6(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", name, act, exp);
    end
  endtask

  task automatic expectFlags(input string name, input logic [4:0] exp);
    expect6(name, {1'b0, dutFlags}, {1'b0, exp});
  endtask

  int p0;

  initial begin
    resetN       = 1'b0;
    bus.din      = 8'h00;
    bus.dinValid = 1'b0;
    repeat (2) @(negedge clk);
    checkEn = 1'b1;
    expect6("reset_state", {bus.keyPressPulse, dutFlags}, 6'b000000);
    @(negedge clk);
    resetN = 1'b1;
    idle(2);

    // 1: plain make / break of KP8
    p0 = pulseCount;
    sendByte(8'h75);
    @(posedge clk); #1;
    expect6("kp8_make", {bus.keyPressPulse, dutFlags}, 6'b101000);
    idle(1);
    @(posedge clk); #1;
    expect6("kp8_pulse_width", {bus.keyPressPulse, dutFlags}, 6'b001000);
    sendByte(8'hF0); sendByte(8'h75); idle(2);
    expectFlags("kp8_break", 5'b00000);
    expect6("kp8_pulse_count", 6'(pulseCount - p0), 6'd1);

    // 2: typematic repeats
    p0 = pulseCount;
    sendByte(8'h6B); sendByte(8'h6B); sendByte(8'h6B); idle(2);
    expectFlags("typematic_held", 5'b00010);
    expect6("typematic_one_pulse", 6'(pulseCount - p0), 6'd1);
    sendByte(8'hF0); sendByte(8'h6B); idle(2);
    expectFlags("typematic_break", 5'b00000);

    // 3: extended aliases
    p0 = pulseCount;
    sendByte(8'hE0); sendByte(8'h72); idle(2);
    expectFlags("ext_down_make", 5'b00001);
    sendByte(8'hE0); sendByte(8'hF0); sendByte(8'h72); idle(2);
    expectFlags("ext_down_break", 5'b00000);
    sendByte(8'hE0); sendByte(8'h5A); idle(2);
    expectFlags("ext_enter_make", 5'b10000);
    sendByte(8'hE0); sendByte(8'hF0); sendByte(8'h5A); idle(2);
    expectFlags("ext_enter_break", 5'b00000);
    expect6("ext_pulse_count", 6'(pulseCount - p0), 6'd2);

    // 4: several keys held together
    sendByte(8'h74); sendByte(8'h75); idle(2);
    expectFlags("multi_make", 5'b01100);
    sendByte(8'hF0); sendByte(8'h74); idle(2);
    expectFlags("multi_partial_break", 5'b01000);
    sendByte(8'hF0); sendByte(8'h75); idle(2);
    expectFlags("multi_all_released", 5'b00000);

    // 5: prefix timeout; expiry cycle is the 16th cycle after the prefix
    sendByte(8'hF0); idle(20); sendByte(8'h75); idle(2);
    expectFlags("timeout_make", 5'b01000);
    sendByte(8'hF0); idle(TIMEOUT - 1); sendByte(8'h75); idle(2);
    expectFlags("expiry_cycle_break", 5'b00000);
    sendByte(8'hF0); idle(TIMEOUT); sendByte(8'h75); idle(2);
    expectFlags("just_after_expiry_make", 5'b01000);
    sendByte(8'hF0); sendByte(8'h75); idle(2);
    expectFlags("timeout_cleanup", 5'b00000);

    // 6: reset in the middle of E0 F0, then unmapped code
    sendByte(8'h74); idle(2);
    sendByte(8'hE0); sendByte(8'hF0); idle(1);
    resetN = 1'b0;
    @(negedge clk);
    expect6("mid_seq_reset", {bus.keyPressPulse, dutFlags}, 6'b000000);
    resetN = 1'b1;
    idle(1);
    sendByte(8'h74); idle(2);
    expectFlags("post_reset_make", 5'b00100);
    p0 = pulseCount;
    sendByte(8'h1C); sendByte(8'hF0); sendByte(8'h1C); idle(2);
    expectFlags("unmapped_no_change", 5'b00100);
    expect6("unmapped_no_pulse", 6'(pulseCount - p0), 6'd0);

    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
